me_ref_search_mem: RTL and testbench

- Memory subsystem feeding the motion-estimator core.
- Holds the 16x16 reference block R (256 bytes) and the 31x31 search window S (961 bytes), both row-major.
- Provides one synchronous read port on R and two independent synchronous read ports on S (S1, S2).
- A load port fills both memories before `start`; it replaces hierarchical memory assignment from the bench.

---
 rtl/me_ref_search_mem_pkg.sv | 16 +
 rtl/me_ref_search_mem_if.sv | 28 ++
 rtl/me_mem_bank.sv | 50 +++++
 rtl/me_ref_search_mem.sv | 57 +++++
 tb/tb_me_ref_search_mem.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/me_ref_search_mem_pkg.sv
// Shared sizes and pixel/address types for the motion-estimator reference/search memories.
package me_ref_search_mem_pkg;

    localparam int DATA_W  = 8;
    localparam int R_DIM   = 16;
    localparam int S_DIM   = 31;
    localparam int R_DEPTH = R_DIM * R_DIM;
    localparam int S_DEPTH = S_DIM * S_DIM;
    localparam int R_AW    = 8;
    localparam int S_AW    = 10;

    typedef logic [DATA_W-1:0] pixel_t;
    typedef logic [R_AW-1:0]   r_addr_t;
    typedef logic [S_AW-1:0]   s_addr_t;

endpackage

// File: rtl/me_ref_search_mem_if.sv
// Read ports and load port between the motion-estimator core and its reference/search memories.
interface me_ref_search_mem_if;
    import me_ref_search_mem_pkg::*;

    r_addr_t AddressR;
    s_addr_t AddressS1;
    s_addr_t AddressS2;
    pixel_t  R;
    pixel_t  S1;
    pixel_t  S2;
    logic    load_en;
    logic    load_sel;
    s_addr_t load_addr;
    pixel_t  load_data;

    modport master (
        output AddressR, AddressS1, AddressS2,
        output load_en, load_sel, load_addr, load_data,
        input  R, S1, S2
    );

    modport slave (
        input  AddressR, AddressS1, AddressS2,
        input  load_en, load_sel, load_addr, load_data,
        output R, S1, S2
    );

endinterface

// File: rtl/me_mem_bank.sv
// Pixel memory with one write port and NRD registered read ports; out-of-range reads return 0,
// out-of-range writes are dropped.
module me_mem_bank
    import me_ref_search_mem_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int RAW   = 8,
    parameter int WAW   = 10,
    parameter int NRD   = 1
) (
    input  logic                      clock,
    input  logic                      rst_n,
    input  logic                      we,
    input  logic [WAW-1:0]            wr_addr,
    input  pixel_t                    wr_data,
    input  logic [NRD-1:0][RAW-1:0]   rd_addr,
    output pixel_t [NRD-1:0]          rd_data
);

    localparam int IW = $clog2(DEPTH);

    pixel_t mem [DEPTH];
    logic   wr_ok;

    // Full-width compare: the write address is never truncated into range.
    assign wr_ok = 32'(wr_addr) < 32'(DEPTH);

    // Contents survive reset; writes are simply blocked while rst_n is low.
    always_ff @(posedge clock or negedge rst_n) begin
        if (rst_n && we && wr_ok) begin
            mem[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    // Nonblocking read of mem gives read-before-write on a same-address collision.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else begin
            for (int p = 0; p < NRD; p++) begin
                if (32'(rd_addr[p]) < 32'(DEPTH)) begin
                    rd_data[p] <= mem[rd_addr[p][IW-1:0]];
                end else begin
                    rd_data[p] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/me_ref_search_mem.sv
// Reference block (16x16) and dual-read search window (31x31) memories for the motion estimator,
// filled through a shared load port.
module me_ref_search_mem
    import me_ref_search_mem_pkg::*;
(
    input  logic                clock,
    input  logic                rst_n,
    me_ref_search_mem_if.slave  bus
);

    logic [0:0][R_AW-1:0] r_addr;
    pixel_t [0:0]         r_q;
    logic [1:0][S_AW-1:0] s_addr;
    pixel_t [1:0]         s_q;
    logic                 r_we;
    logic                 s_we;

    assign r_we   = bus.load_en & ~bus.load_sel;
    assign s_we   = bus.load_en &  bus.load_sel;
    assign r_addr = bus.AddressR;
    assign s_addr = {bus.AddressS2, bus.AddressS1};

    me_mem_bank #(
        .DEPTH (R_DEPTH),
        .RAW   (R_AW),
        .WAW   (S_AW),
        .NRD   (1)
    ) u_r_bank (
        .clock   (clock),
        .rst_n   (rst_n),
        .we      (r_we),
        .wr_addr (bus.load_addr),
        .wr_data (bus.load_data),
        .rd_addr (r_addr),
        .rd_data (r_q)
    );

    me_mem_bank #(
        .DEPTH (S_DEPTH),
        .RAW   (S_AW),
        .WAW   (S_AW),
        .NRD   (2)
    ) u_s_bank (
        .clock   (clock),
        .rst_n   (rst_n),
        .we      (s_we),
        .wr_addr (bus.load_addr),
        .wr_data (bus.load_data),
        .rd_addr (s_addr),
        .rd_data (s_q)
    );

    assign bus.R  = r_q[0];
    assign bus.S1 = s_q[0];
    assign bus.S2 = s_q[1];

endmodule

// File: tb/tb_me_ref_search_mem.sv
// Bench for me_ref_search_mem: array model of both memories, directed tables and sequences, random traffic.
module tb_me_ref_search_mem;
    import me_ref_search_mem_pkg::*;

    logic clock = 1'b0;
    logic rst_n;
    always #5 clock = ~clock;

    me_ref_search_mem_if bus ();

    me_ref_search_mem dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    logic [7:0] rmodel [256];
    logic [7:0] smodel [961];

    typedef struct {
        string      name;
        logic [9:0] a1;
        logic [9:0] a2;
        logic [7:0] e1;
        logic [7:0] e2;
    } s_vec_t;

    s_vec_t svec [5];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic [7:0] ar, input logic [9:0] a1, input logic [9:0] a2,
                         input logic we, input logic sel, input logic [9:0] wa, input logic [7:0] wd);
        bus.AddressR  = ar;
        bus.AddressS1 = a1;
        bus.AddressS2 = a2;
        bus.load_en   = we;
        bus.load_sel  = sel;
        bus.load_addr = wa;
        bus.load_data = wd;
    endtask

    // One clock: predict from the memory image before this edge's write, then apply the write.
    task automatic step(input bit chk);
        logic [7:0] er, e1, e2;
        er = 8'h00; e1 = 8'h00; e2 = 8'h00;
        if (rst_n) begin
            er = rmodel[bus.AddressR];
            if (bus.AddressS1 < 961) e1 = smodel[bus.AddressS1];
            if (bus.AddressS2 < 961) e2 = smodel[bus.AddressS2];
            if (bus.load_en) begin
                if (!bus.load_sel) begin
                    if (bus.load_addr < 256) rmodel[bus.load_addr[7:0]] = bus.load_data;
                end else if (bus.load_addr < 961) begin
                    smodel[bus.load_addr] = bus.load_data;
                end
            end
        end
        @(posedge clock);
        #1;
        if (chk) begin
            check("R", bus.R, er);
            check("S1", bus.S1, e1);
            check("S2", bus.S2, e2);
        end
    endtask

    initial begin
        svec[0] = '{"s_corner",  10'd0,    10'd960,  8'h00, 8'hC0};
        svec[1] = '{"s_same",    10'd500,  10'd500,  8'hF4, 8'hF4};
        svec[2] = '{"s_oor",     10'd961,  10'd1023, 8'h00, 8'h00};
        svec[3] = '{"s_mixed",   10'd255,  10'd256,  8'hFF, 8'h00};
        svec[4] = '{"s_edge",    10'd959,  10'd1,    8'hBF, 8'h01};

        for (int i = 0; i < 256; i++) rmodel[i] = 8'h00;
        for (int i = 0; i < 961; i++) smodel[i] = 8'h00;

        rst_n = 1'b0;
        drive(8'd0, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);
        #1;
        check("por_R", bus.R, 8'h00);
        check("por_S1", bus.S1, 8'h00);
        check("por_S2", bus.S2, 8'h00);
        @(posedge clock);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) begin
            drive(8'd0, 10'd0, 10'd0, 1'b1, 1'b0, 10'(i), 8'(i));
            step(1'b0);
        end

        // Held reset with a write attempt to R[5]: outputs stay 0 and the write is dropped.
        drive(8'd5, 10'd5, 10'd5, 1'b1, 1'b0, 10'd5, 8'hAA);
        rst_n = 1'b0;
        #1;
        check("rst_async_R", bus.R, 8'h00);
        for (int c = 0; c < 3; c++) step(1'b1);
        drive(8'd5, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);
        rst_n = 1'b1;
        check("rst_hold_R", bus.R, 8'h00);
        step(1'b1);
        check("rst_release_R", bus.R, 8'h05);

        for (int a = 0; a < 256; a++) begin
            drive(8'(a), 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);
            step(1'b0);
            check("r_sweep", bus.R, 8'(a));
        end
        check("r_last", bus.R, 8'hFF);

        for (int k = 0; k < 961; k++) begin
            drive(8'd0, 10'd0, 10'd0, 1'b1, 1'b1, 10'(k), 8'(k % 256));
            step(1'b0);
        end

        foreach (svec[i]) begin
            drive(8'd0, svec[i].a1, svec[i].a2, 1'b0, 1'b0, 10'd0, 8'd0);
            step(1'b1);
            check({svec[i].name, "_S1"}, bus.S1, svec[i].e1);
            check({svec[i].name, "_S2"}, bus.S2, svec[i].e2);
        end

        drive(8'd0, 10'd0, 10'd0, 1'b1, 1'b1, 10'd970, 8'h5A);
        step(1'b1);
        for (int k = 0; k < 961; k++) begin
            drive(8'(k % 256), 10'(k), 10'(960 - k), 1'b0, 1'b0, 10'd0, 8'd0);
            step(1'b1);
            check("s_full_S1", bus.S1, 8'(k % 256));
        end

        drive(8'd0, 10'd0, 10'd0, 1'b1, 1'b0, 10'd10, 8'h11);
        step(1'b1);
        drive(8'd10, 10'd0, 10'd0, 1'b1, 1'b0, 10'd10, 8'h22);
        step(1'b1);
        check("coll_old", bus.R, 8'h11);
        drive(8'd10, 10'd0, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);
        step(1'b1);
        check("coll_new", bus.R, 8'h22);

        // Half-cycle reset pulse in the middle of an S sweep.
        for (int k = 290; k <= 320; k++) begin
            drive(8'(k % 256), 10'(k), 10'(k + 1), 1'b0, 1'b0, 10'd0, 8'd0);
            step(1'b1);
            if (k == 300) begin
                #1 rst_n = 1'b0;
                #1;
                check("mid_rst_R", bus.R, 8'h00);
                check("mid_rst_S1", bus.S1, 8'h00);
                check("mid_rst_S2", bus.S2, 8'h00);
                #4 rst_n = 1'b1;
            end
        end
        drive(8'd0, 10'd300, 10'd0, 1'b0, 1'b0, 10'd0, 8'd0);
        step(1'b1);
        check("mid_rst_keep", bus.S1, 8'h2C);

        for (int n = 0; n < 3000; n++) begin
            drive(8'($urandom), 10'($urandom_range(0, 1023)), 10'($urandom_range(0, 1023)),
                  1'($urandom_range(0, 3) == 0), 1'($urandom), 10'($urandom_range(0, 1023)),
                  8'($urandom));
            step(1'b1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
